bus_arbiter: RTL

//   Round-robin arbiter and data mux for the shared 16-bit datapath bus.

---
 rtl/bus_arbiter.sv | 108 ++++++++++
 1 files changed

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with registered one-hot grant and combinational data mux.
// Ownership changes always pass through an idle cycle; the hold time is bounded by
// MAX_HOLD unless the owner asserts lock or is the only requester.
//
// state   | meaning
// S_IDLE  | no owner, gnt=0, picks the next winner from ptr onwards
// S_GRANT | owner holds the bus until release or preemption
module bus_arbiter #(
  parameter int NREQ       = 4,
  parameter int WIDTH      = 16,
  parameter int MAX_HOLD   = 8,
  localparam int OW        = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       lock,
  input  logic [NREQ*WIDTH-1:0] data,
  output logic [NREQ-1:0]       gnt,
  output logic [OW-1:0]         owner,
  output logic                  busy,
  output logic [WIDTH-1:0]      out
);

  localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HW-1:0] HOLD_TOP = HW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_GRANT = 1'b1;

  logic [0:0]    state;
  logic [OW-1:0] ptr;
  logic [HW-1:0] hold_cnt;

  logic          found;
  logic [OW-1:0] winner;
  logic [OW:0]   idx;
  logic          preempt;
  logic [OW-1:0] next_ptr;

  // Round-robin search: first set request starting at ptr, wrapping mod NREQ.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = {1'b0, ptr} + (OW+1)'(k);
      if (idx >= (OW+1)'(NREQ)) idx = idx - (OW+1)'(NREQ);
      if (!found && req[idx[OW-1:0]]) begin
        found  = 1'b1;
        winner = idx[OW-1:0];
      end
    end
  end

  // Preemption needs a saturated hold count, no lock from the owner and another
  // waiting requester; gnt is one-hot of owner while granted.
  always_comb begin
    preempt  = (MAX_HOLD != 0) && (hold_cnt == HOLD_TOP) && !lock[owner] &&
               (|(req & ~gnt));
    next_ptr = (owner == OW'(NREQ - 1)) ? '0 : owner + 1'b1;
  end

  // Arbitration state, grant and hold counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_IDLE;
      gnt      <= '0;
      owner    <= '0;
      ptr      <= '0;
      hold_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (found) begin
            state    <= S_GRANT;
            gnt      <= {{(NREQ-1){1'b0}}, 1'b1} << winner;
            owner    <= winner;
            hold_cnt <= '0;
          end
        end
        S_GRANT: begin
          if (!req[owner] || preempt) begin
            state <= S_IDLE;
            gnt   <= '0;
            ptr   <= next_ptr;
          end else if (hold_cnt != HOLD_TOP) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          gnt   <= '0;
        end
      endcase
    end
  end

  // Bus mux driven straight from the registered grant, zero when nobody owns it.
  always_comb begin
    busy = |gnt;
    out  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) out = data[i*WIDTH +: WIDTH];
    end
  end

endmodule
